// File: rtl/peripheral_msi_decoder_wb.sv
// peripheral_msi_decoder_wb
// Single-master to NUM_SLAVES Wishbone address decoder/router. The master address
// is decoded once at the start of a cycle; the chosen slave then stays locked
// for the rest of that cycle, including bursts. Unmapped accesses and slaves
// that never respond finish with a bus error. The master is held in DRAIN until
// it releases cyc.
module peripheral_msi_decoder_wb #(
  parameter int NUM_SLAVES = 4,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = {32'h0000_0300, 32'h0000_0200,
                                                   32'h0000_0100, 32'h0000_0000},
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = {NUM_SLAVES{32'hFFFF_FF00}},
  parameter int TIMEOUT    = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [AW-1:0]            wbm_adr_i,
  input  logic [DW-1:0]            wbm_dat_i,
  input  logic [DW/8-1:0]          wbm_sel_i,
  input  logic                     wbm_we_i,
  input  logic                     wbm_cyc_i,
  input  logic                     wbm_stb_i,
  input  logic [2:0]               wbm_cti_i,
  input  logic [1:0]               wbm_bte_i,
  output logic [DW-1:0]            wbm_dat_o,
  output logic                     wbm_ack_o,
  output logic                     wbm_err_o,
  output logic                     wbm_rty_o,
  output logic [NUM_SLAVES*AW-1:0] wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0] wbs_dat_o,
  output logic [NUM_SLAVES*DW/8-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]    wbs_we_o,
  output logic [NUM_SLAVES*3-1:0]  wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]  wbs_bte_o,
  output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]    wbs_stb_o,
  input  logic [NUM_SLAVES*DW-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]    wbs_err_i,
  input  logic [NUM_SLAVES-1:0]    wbs_rty_i,
  output logic                     decode_err_o,
  output logic                     timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // The counter holds the number of silent cycles already seen. The abort
  // therefore fires in the TIMEOUT-th silent cycle.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ERR   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [SW-1:0] sel_r;
  logic [SW-1:0] dec_idx_s;
  logic          hit_s;
  logic [CW-1:0] cnt_r;
  logic          sel_ack_s, sel_err_s, sel_rty_s, resp_s, timeout_s;

  // Address, data and qualifiers are broadcast. Only cyc/stb are routed.
  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

  assign sel_ack_s = wbs_ack_i[sel_r];
  assign sel_err_s = wbs_err_i[sel_r];
  assign sel_rty_s = wbs_rty_i[sel_r];
  assign resp_s    = sel_ack_s | sel_err_s | sel_rty_s;
  // A response that arrives in the expiring cycle takes priority over the abort.
  assign timeout_s = (state_r == BUSY) & wbm_cyc_i & wbm_stb_i & ~resp_s & (cnt_r == TO_LAST);

  // Address window decode: scanning downwards lets the lowest matching index win.
  always_comb begin
    hit_s     = 1'b0;
    dec_idx_s = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((wbm_adr_i & MATCH_MASK[i*AW +: AW]) == (MATCH_ADDR[i*AW +: AW] & MATCH_MASK[i*AW +: AW])) begin
        hit_s     = 1'b1;
        dec_idx_s = SW'(i);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Next-state logic plus the routing of cyc/stb and master responses.
  always_comb begin
    state_s      = state_r;
    wbs_cyc_o    = '0;
    wbs_stb_o    = '0;
    wbm_ack_o    = 1'b0;
    wbm_err_o    = 1'b0;
    wbm_rty_o    = 1'b0;
    wbm_dat_o    = '0;
    decode_err_o = 1'b0;
    timeout_o    = 1'b0;
    case (state_r)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (hit_s) begin
            state_s = BUSY;
          end else begin
            state_s = ERR;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (!wbm_cyc_i) begin
          state_s = IDLE;
        end else if (timeout_s) begin
          wbm_err_o = 1'b1;
          timeout_o = 1'b1;
          state_s   = DRAIN;
        end else begin
          wbs_cyc_o[sel_r] = 1'b1;
          wbs_stb_o[sel_r] = wbm_stb_i;
          wbm_ack_o        = sel_ack_s;
          wbm_err_o        = sel_err_s;
          wbm_rty_o        = sel_rty_s;
          wbm_dat_o        = wbs_dat_i[sel_r*DW +: DW];
        end
      end
      ERR: begin
        wbm_err_o    = 1'b1;
        decode_err_o = 1'b1;
        if (wbm_cyc_i) begin
          state_s = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (!wbm_cyc_i) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, locked slave selection and the no-response watchdog counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      sel_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && wbm_cyc_i && wbm_stb_i && hit_s) begin
        sel_r <= dec_idx_s;
      end else begin
        sel_r <= sel_r;
      end
      if ((state_r != BUSY) || !wbm_stb_i || resp_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_peripheral_msi_decoder_wb.sv
// Directed testbench for peripheral_msi_decoder_wb (TIMEOUT=16, default windows).
// Inputs change just after the falling edge. Outputs are checked 1 time unit later.
module tb_peripheral_msi_decoder_wb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   wdat;
  logic [DW/8-1:0] sel;
  logic            we, cyc, stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   wbm_dat_o;
  logic            wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [N*AW-1:0] wbs_adr_o;
  logic [N*DW-1:0] wbs_dat_o;
  logic [N*DW/8-1:0] wbs_sel_o;
  logic [N-1:0]    wbs_we_o;
  logic [N*3-1:0]  wbs_cti_o;
  logic [N*2-1:0]  wbs_bte_o;
  logic [N-1:0]    wbs_cyc_o, wbs_stb_o;
  logic [N*DW-1:0] wbs_dat_i;
  logic [N-1:0]    wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic            decode_err_o, timeout_o;

  int n_vec;
  int n_bad;

  peripheral_msi_decoder_wb #(.TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(adr), .wbm_dat_i(wdat), .wbm_sel_i(sel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .decode_err_o(decode_err_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it miscompares.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; adr = '0; wdat = 32'h1234_5678; sel = 4'hF; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
    wbs_dat_i = '0; wbs_ack_i = '0; wbs_err_i = '0; wbs_rty_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("rst_stb", 64'(wbs_stb_o), 64'h0);
    chk("rst_resp", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o, decode_err_o, timeout_o}), 64'h0);
    chk("rst_dat", 64'(wbm_dat_o), 64'h0);
    @(negedge clk); rst = 1'b0;

    // Read 0x104 -> slave1
    @(negedge clk); adr = 32'h104; we = 1'b0; cyc = 1'b1; stb = 1'b1; #1;
    chk("rd_decode_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("rd_bcast_adr", 64'(wbs_adr_o[63:32]), 64'h104);
    chk("rd_bcast_dat", 64'(wbs_dat_o[127:96]), 64'h1234_5678);
    @(negedge clk); wbs_dat_i[63:32] = 32'hDEAD_BEEF; wbs_ack_i = 4'b0010; #1;
    chk("rd_cyc", 64'(wbs_cyc_o), 64'h2);
    chk("rd_stb", 64'(wbs_stb_o), 64'h2);
    chk("rd_ack", 64'(wbm_ack_o), 64'h1);
    chk("rd_dat", 64'(wbm_dat_o), 64'hDEAD_BEEF);
    @(negedge clk); cyc = 1'b0; stb = 1'b0; wbs_ack_i = '0; #1;
    chk("rd_end_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("rd_end_ack", 64'(wbm_ack_o), 64'h0);

    // Slave2 retry and error responses are forwarded
    @(negedge clk); adr = 32'h204; cyc = 1'b1; stb = 1'b1; #1;
    @(negedge clk); wbs_rty_i = 4'b0100; #1;
    chk("rty_fwd", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'h1);
    @(negedge clk); wbs_rty_i = '0; wbs_err_i = 4'b0100; #1;
    chk("err_fwd", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o, decode_err_o, timeout_o}), 64'h8);
    @(negedge clk); wbs_err_i = '0; cyc = 1'b0; stb = 1'b0;

    // Unmapped write 0x500
    @(negedge clk); adr = 32'h500; we = 1'b1; cyc = 1'b1; stb = 1'b1; #1;
    chk("unm_decode", 64'({wbs_cyc_o, wbm_err_o, decode_err_o}), 64'h0);
    @(negedge clk); #1;
    chk("unm_err", 64'({wbm_err_o, decode_err_o}), 64'h3);
    chk("unm_cyc", 64'(wbs_cyc_o), 64'h0);
    @(negedge clk); #1;
    chk("unm_drain1", 64'({wbs_cyc_o, wbm_err_o, decode_err_o, wbm_ack_o}), 64'h0);
    @(negedge clk); stb = 1'b0; #1;
    chk("unm_drain2", 64'({wbs_cyc_o, wbm_err_o, decode_err_o, wbm_ack_o}), 64'h0);
    @(negedge clk); cyc = 1'b0; we = 1'b0;

    // Timeout on silent slave2
    @(negedge clk); adr = 32'h208; cyc = 1'b1; stb = 1'b1; #1;
    chk("to_decode", 64'(wbs_cyc_o), 64'h0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      chk("to_wait_cyc", 64'(wbs_cyc_o), 64'h4);
      chk("to_wait_err", 64'({wbm_err_o, timeout_o}), 64'h0);
    end
    @(negedge clk); #1;
    chk("to_fire", 64'({wbm_err_o, timeout_o, decode_err_o}), 64'h6);
    chk("to_fire_cyc", 64'(wbs_cyc_o), 64'h0);
    @(negedge clk); #1;
    chk("to_drain", 64'({wbs_cyc_o, wbm_err_o, timeout_o, wbm_ack_o}), 64'h0);
    @(negedge clk); cyc = 1'b0; stb = 1'b0;

    // 4-beat incrementing burst to slave3, one decode cycle
    @(negedge clk); adr = 32'h300; cti = 3'b010; cyc = 1'b1; stb = 1'b1; #1;
    chk("bu_decode", 64'(wbs_cyc_o), 64'h0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      adr = 32'h300 + 32'(4 * b);
      cti = (b == 3) ? 3'b111 : 3'b010;
      wbs_ack_i = 4'b1000;
      wbs_dat_i[127:96] = 32'hA000_0000 + 32'(b);
      #1;
      chk("bu_stb", 64'(wbs_stb_o), 64'h8);
      chk("bu_ack", 64'(wbm_ack_o), 64'h1);
      chk("bu_dat", 64'(wbm_dat_o), 64'hA000_0000 + 64'(b));
      chk("bu_cti", 64'(wbs_cti_o[11:9]), 64'(cti));
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0; wbs_ack_i = '0; cti = 3'b000; #1;
    chk("bu_end", 64'(wbs_cyc_o), 64'h0);

    // Slave0 answers in the expiring cycle: ack wins over timeout
    @(negedge clk); adr = 32'h010; cyc = 1'b1; stb = 1'b1; #1;
    chk("late_decode", 64'(wbs_cyc_o), 64'h0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      chk("late_wait", 64'({wbs_cyc_o, wbm_ack_o, wbm_err_o}), 64'h4);
    end
    @(negedge clk); wbs_ack_i = 4'b0001; wbs_dat_i[31:0] = 32'h5A5A_5A5A; #1;
    chk("late_ack", 64'({wbm_ack_o, wbm_err_o, timeout_o}), 64'h4);
    chk("late_cyc", 64'(wbs_cyc_o), 64'h1);
    chk("late_dat", 64'(wbm_dat_o), 64'h5A5A_5A5A);
    @(negedge clk); cyc = 1'b0; stb = 1'b0; wbs_ack_i = '0;

    // Reset while busy on slave1, then a new request to slave0
    @(negedge clk); adr = 32'h104; cyc = 1'b1; stb = 1'b1; #1;
    @(negedge clk); #1;
    chk("rb_busy", 64'(wbs_cyc_o), 64'h2);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; adr = 32'h004; wbs_ack_i = 4'b0010; #1;
    chk("rb_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("rb_ack", 64'(wbm_ack_o), 64'h0);
    @(negedge clk); wbs_ack_i = '0; #1;
    chk("rb_new", 64'(wbs_cyc_o), 64'h1);
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
